// File: rtl/muldiv_pkg.sv
// Shared types and opcode decode helpers for the iterative M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_high(muldiv_op_e op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op[2] && op[1];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle, with divide-by-zero and
// signed-overflow fast paths, and a flush that aborts any in-flight operation.
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_in, op_q;
  logic            accept, fast;
  logic            a_neg, b_neg, res_neg, neg_q;
  logic            div_zero, div_ovf, div_ok;
  logic [XLEN-1:0] a_mag, b_mag, b_q, fast_res, fix_res, result_q;
  logic [2*XLEN-1:0] acc_q, fix_in, fix_out;
  logic [XLEN:0]   rem_q, mul_sum, div_shift;
  logic [XLEN+1:0] div_diff;
  logic [CW-1:0]   cnt_q;

  assign op_in   = muldiv_op_e'(op);
  assign a_neg   = is_signed_a(op_in) & operand_a[XLEN-1];
  assign b_neg   = is_signed_b(op_in) & operand_b[XLEN-1];
  // Remainder follows the dividend; everything else follows the sign product.
  assign res_neg = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

  muldiv_negate #(.W(XLEN)) u_neg_a (.neg(a_neg), .din(operand_a), .dout(a_mag));
  muldiv_negate #(.W(XLEN)) u_neg_b (.neg(b_neg), .din(operand_b), .dout(b_mag));

  assign div_zero = is_div(op_in) && (operand_b == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (operand_a == MIN_INT) && (operand_b == '1);
  assign fast     = div_zero | div_ovf;
  assign fast_res = div_zero ? (is_rem(op_in) ? operand_a : '1)
                             : (is_rem(op_in) ? '0 : MIN_INT);

  // Shift-add multiply: acc low half holds the multiplier, high half the partial sum.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // Restoring divide: acc low half shifts dividend bits out and quotient bits in.
  assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  assign div_ok    = !div_diff[XLEN+1];

  assign fix_in  = !is_div(op_q) ? acc_q :
                   is_rem(op_q)  ? {{(XLEN-1){1'b0}}, rem_q} :
                                   {{XLEN{1'b0}}, acc_q[XLEN-1:0]};

  muldiv_negate #(.W(2*XLEN)) u_neg_fix (.neg(neg_q), .din(fix_in), .dout(fix_out));

  assign fix_res = is_high(op_q) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
  assign result  = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    busy    = (state_q == S_CALC) || (state_q == S_FIX);
    done    = (state_q == S_DONE);
    accept  = start & ready & ~flush;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = accept ? (fast ? S_DONE : S_CALC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      neg_q <= res_neg;
      b_q   <= b_mag;
      acc_q <= {{XLEN{1'b0}}, a_mag};
      rem_q <= '0;
      cnt_q <= CW'(XLEN-1);
      if (fast) result_q <= fast_res;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (is_div(op_q)) begin
        rem_q             <= div_ok ? div_diff[XLEN:0] : div_shift;
        acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], div_ok};
      end else begin
        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
      end
    end else if ((state_q == S_FIX) && !flush) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit; runs every scenario at XLEN=32 and XLEN=16.
module tb_muldiv_seq_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start32, start16, flush;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        ready32, busy32, done32, ready16, busy16, done16;
  logic [31:0] result32;
  logic [15:0] result16;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op),
    .operand_a(opa), .operand_b(opb), .flush(flush),
    .ready(ready32), .busy(busy32), .done(done32), .result(result32)
  );

  muldiv_seq_unit #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op),
    .operand_a(opa[15:0]), .operand_b(opb[15:0]), .flush(flush),
    .ready(ready16), .busy(busy16), .done(done16), .result(result16)
  );

  function automatic logic f_rdy(input int w); return (w == 32) ? ready32 : ready16; endfunction
  function automatic logic f_bsy(input int w); return (w == 32) ? busy32 : busy16; endfunction
  function automatic logic f_dn(input int w);  return (w == 32) ? done32 : done16; endfunction
  function automatic logic [31:0] f_res(input int w);
    return (w == 32) ? result32 : {16'h0000, result16};
  endfunction
  function automatic logic [31:0] msk(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 32) start32 = v;
    else         start16 = v;
  endtask

  // Issues one operation and waits (bounded) for its done pulse.
  task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bc, output logic got);
    int guard = 0;
    while (!f_rdy(w) && guard < 100) begin @(posedge clk); #1; guard++; end
    op = o; opa = a; opb = b;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    opa = $urandom(); opb = $urandom(); op = 3'($urandom_range(7, 0));
    lat = 1; bc = 0;
    while (!f_dn(w) && lat < 200) begin
      if (f_bsy(w)) bc++;
      @(posedge clk); #1; lat++;
    end
    if (f_bsy(w)) bc++;
    got = f_dn(w);
    r = f_res(w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start32 = 1'b0; start16 = 1'b0; flush = 1'b0;
    op = 3'b000; opa = '0; opb = '0;
    #22;
    for (int i = 0; i < 2; i++) begin
      int w = (i == 0) ? 32 : 16;
      total++; if (f_rdy(w) !== 1'b1) begin bad++; $display("FAIL reset_ready w=%0d got=%b exp=1", w, f_rdy(w)); end
      total++; if (f_bsy(w) !== 1'b0) begin bad++; $display("FAIL reset_busy w=%0d got=%b exp=0", w, f_bsy(w)); end
      total++; if (f_dn(w) !== 1'b0) begin bad++; $display("FAIL reset_done w=%0d got=%b exp=0", w, f_dn(w)); end
      total++; if (f_res(w) !== 32'h0) begin bad++; $display("FAIL reset_result w=%0d got=%h exp=0", w, f_res(w)); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul(input int w);
    logic [2:0]  ov [4] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU};
    logic [31:0] av [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] m, r;
    int lat, bc;
    logic got;
    m = msk(w);
    for (int i = 0; i < 4; i++) begin
      run_op(w, ov[i], av[i] & m, bv[i] & m, r, lat, bc, got);
      total++; if (!got || r !== (ev[i] & m)) begin bad++; $display("FAIL mul_result[%0d] w=%0d got=%h done=%b exp=%h", i, w, r, got, ev[i] & m); end
      total++; if (lat !== w + 2) begin bad++; $display("FAIL mul_latency[%0d] w=%0d got=%0d exp=%0d", i, w, lat, w + 2); end
      total++; if (bc !== w + 1) begin bad++; $display("FAIL mul_busy[%0d] w=%0d got=%0d exp=%0d", i, w, bc, w + 1); end
    end
  endtask

  task automatic test_div(input int w);
    logic [2:0]  ov [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] av [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd7, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    logic [31:0] bv [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                            32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] ev [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                            32'hFFFF_FFFD, 32'd1, 32'd14, 32'hFFFF_FFFE};
    logic [31:0] m, r;
    int lat, bc;
    logic got;
    m = msk(w);
    for (int i = 0; i < 8; i++) begin
      run_op(w, ov[i], av[i] & m, bv[i] & m, r, lat, bc, got);
      total++; if (!got || r !== (ev[i] & m)) begin bad++; $display("FAIL div_result[%0d] w=%0d got=%h done=%b exp=%h", i, w, r, got, ev[i] & m); end
      total++; if (lat !== w + 2) begin bad++; $display("FAIL div_latency[%0d] w=%0d got=%0d exp=%0d", i, w, lat, w + 2); end
    end
  endtask

  task automatic test_fast(input int w);
    logic [2:0]  ov [6] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REMU};
    logic [31:0] av [6], bv [6], ev [6];
    logic [31:0] m, mn, r;
    int lat, bc;
    logic got;
    m  = msk(w);
    mn = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
    av = '{32'd5, 32'd5, mn, mn, 32'd5, 32'd5};
    bv = '{32'd0, 32'd0, m, m, 32'd0, 32'd0};
    ev = '{m, 32'd5, mn, 32'd0, m, 32'd5};
    for (int i = 0; i < 6; i++) begin
      run_op(w, ov[i], av[i], bv[i], r, lat, bc, got);
      total++; if (!got || r !== ev[i]) begin bad++; $display("FAIL fast_result[%0d] w=%0d got=%h done=%b exp=%h", i, w, r, got, ev[i]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL fast_latency[%0d] w=%0d got=%0d exp=1", i, w, lat); end
      total++; if (bc !== 0) begin bad++; $display("FAIL fast_busy[%0d] w=%0d got=%0d exp=0", i, w, bc); end
    end
  endtask

  task automatic test_flush(input int w);
    logic [31:0] r;
    int lat, bc;
    logic got;
    run_op(w, OP_DIVU, 32'd100, 32'd7, r, lat, bc, got);
    total++; if (!got || r !== 32'd14) begin bad++; $display("FAIL flush_prior w=%0d got=%h exp=%h", w, r, 32'd14); end
    op = OP_MUL; opa = 32'd7; opb = 32'hFFFF_FFFD & msk(w);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (f_rdy(w) !== 1'b1) begin bad++; $display("FAIL flush_ready w=%0d got=%b exp=1", w, f_rdy(w)); end
    total++; if (f_bsy(w) !== 1'b0) begin bad++; $display("FAIL flush_busy w=%0d got=%b exp=0", w, f_bsy(w)); end
    total++; if (f_dn(w) !== 1'b0) begin bad++; $display("FAIL flush_done w=%0d got=%b exp=0", w, f_dn(w)); end
    total++; if (f_res(w) !== 32'd14) begin bad++; $display("FAIL flush_hold w=%0d got=%h exp=%h", w, f_res(w), 32'd14); end
    run_op(w, OP_REMU, 32'd100, 32'd7, r, lat, bc, got);
    total++; if (!got || r !== 32'd2) begin bad++; $display("FAIL flush_next_result w=%0d got=%h exp=%h", w, r, 32'd2); end
    total++; if (lat !== w + 2) begin bad++; $display("FAIL flush_next_latency w=%0d got=%0d exp=%0d", w, lat, w + 2); end
  endtask

  task automatic test_start_in_calc(input int w);
    int lat = 1;
    int extra = 0;
    op = OP_MUL; opa = 32'd7; opb = 32'hFFFF_FFFD & msk(w);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    repeat (4) begin @(posedge clk); #1; lat++; end
    op = OP_DIVU; opa = 32'd100; opb = 32'd7;
    set_start(w, 1'b1);
    total++; if (f_rdy(w) !== 1'b0) begin bad++; $display("FAIL calc_ready w=%0d got=%b exp=0", w, f_rdy(w)); end
    @(posedge clk); #1; lat++;
    set_start(w, 1'b0);
    while (!f_dn(w) && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (!f_dn(w) || f_res(w) !== (32'hFFFF_FFEB & msk(w))) begin bad++; $display("FAIL calc_ignore_result w=%0d got=%h exp=%h", w, f_res(w), 32'hFFFF_FFEB & msk(w)); end
    total++; if (lat !== w + 2) begin bad++; $display("FAIL calc_ignore_latency w=%0d got=%0d exp=%0d", w, lat, w + 2); end
    repeat (w + 6) begin @(posedge clk); #1; if (f_dn(w)) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL calc_ignore_extra_done w=%0d got=%0d exp=0", w, extra); end
  endtask

  task automatic test_back_to_back(input int w);
    logic [31:0] r;
    int lat, bc;
    logic got;
    run_op(w, OP_MUL, 32'd7, 32'hFFFF_FFFD & msk(w), r, lat, bc, got);
    total++; if (!got || r !== (32'hFFFF_FFEB & msk(w))) begin bad++; $display("FAIL b2b_first w=%0d got=%h exp=%h", w, r, 32'hFFFF_FFEB & msk(w)); end
    op = OP_DIVU; opa = 32'd100; opb = 32'd7;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    total++; if (f_dn(w) !== 1'b0 || f_bsy(w) !== 1'b1) begin bad++; $display("FAIL b2b_accept w=%0d got done=%b busy=%b exp done=0 busy=1", w, f_dn(w), f_bsy(w)); end
    lat = 1;
    while (!f_dn(w) && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (!f_dn(w) || f_res(w) !== 32'd14) begin bad++; $display("FAIL b2b_second w=%0d got=%h exp=%h", w, f_res(w), 32'd14); end
    total++; if (lat !== w + 2) begin bad++; $display("FAIL b2b_spacing w=%0d got=%0d exp=%0d", w, lat, w + 2); end
  endtask

  task automatic test_async_reset(input int w);
    logic [31:0] r;
    int lat, bc;
    int extra = 0;
    logic got;
    run_op(w, OP_DIVU, 32'd100, 32'd7, r, lat, bc, got);
    op = OP_MUL; opa = 32'd7; opb = 32'd9;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (f_rdy(w) !== 1'b1) begin bad++; $display("FAIL arst_ready w=%0d got=%b exp=1", w, f_rdy(w)); end
    total++; if (f_bsy(w) !== 1'b0) begin bad++; $display("FAIL arst_busy w=%0d got=%b exp=0", w, f_bsy(w)); end
    total++; if (f_dn(w) !== 1'b0) begin bad++; $display("FAIL arst_done w=%0d got=%b exp=0", w, f_dn(w)); end
    total++; if (f_res(w) !== 32'h0) begin bad++; $display("FAIL arst_result w=%0d got=%h exp=0", w, f_res(w)); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (w + 6) begin @(posedge clk); #1; if (f_dn(w)) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL arst_no_done w=%0d got=%0d exp=0", w, extra); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 2; i++) begin
      int w = (i == 0) ? 32 : 16;
      test_mul(w);
      test_div(w);
      test_fast(w);
      test_flush(w);
      test_start_in_calc(w);
      test_back_to_back(w);
      test_async_reset(w);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
